// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: register map, CTRL/STATUS bit
// positions and FSM state encoding.
package countdown_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_PER   = 1;
    localparam int CTRL_IE    = 2;
    localparam int STATUS_EXP = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // CTRL read-back word; all bits other than EN/PER/IE read as zero.
    function automatic logic [31:0] ctrl_word(input logic en, input logic per, input logic ie);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN]  = en;
        w[CTRL_PER] = per;
        w[CTRL_IE]  = ie;
        return w;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Register-bus bundle for the countdown timer (select, write data/enable,
// read data and interrupt).
interface countdown_timer_if;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        irq;

    modport master (output A, output WD, output WE, input RD, input irq);
    modport slave  (input A, input WD, input WE, output RD, output irq);
endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..F_DIV while run is high and pulses tick on F_DIV,
// giving one tick every F_DIV+1 cycles. clr forces the count back to 0.
module tick_gen #(
    parameter int F_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = ($clog2(F_DIV + 1) > 0) ? $clog2(F_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(F_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Register-mapped countdown timer with IDLE/RUN/DONE control and a level irq.
// Periodic reload (CTRL.PER) exists only when COUNTDOWN_TIMER_AUTORELOAD_EN is defined.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int F_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        irq
);
    logic [1:0]  state_q, state_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        ie_q, ie_d;
    logic        per_q, per_d;
    logic        exp_q, exp_d;
    logic        tick, presc_clr, expire;
    logic        wr_ctrl, wr_load, wr_status;

    assign wr_ctrl   = WE && (A == REG_CTRL);
    assign wr_load   = WE && (A == REG_LOAD);
    assign wr_status = WE && (A == REG_STATUS);

    tick_gen #(.F_DIV(F_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .run  (state_q == ST_RUN),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        count_d   = count_q;
        ie_d      = ie_q;
        per_d     = per_q;
        presc_clr = 1'b0;
        expire    = 1'b0;

        if (wr_load) begin
            load_d = WD;
        end

        // A CTRL write overrides a tick landing in the same cycle.
        if (wr_ctrl) begin
            ie_d = WD[CTRL_IE];
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            per_d = WD[CTRL_PER];
`else
            per_d = 1'b0;
`endif
            if (WD[CTRL_EN]) begin
                count_d   = load_q;
                presc_clr = 1'b1;
                state_d   = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_RUN) && tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (per_q) begin
                    count_d = load_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end

        // Set has priority over the W1C clear.
        exp_d = exp_q;
        if (wr_status && WD[STATUS_EXP]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            load_q  <= '0;
            count_q <= '0;
            ie_q    <= 1'b0;
            per_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            count_q <= count_d;
            ie_q    <= ie_d;
            per_q   <= per_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            REG_CTRL:   RD = ctrl_word(state_q == ST_RUN, per_q, ie_q);
            REG_LOAD:   RD = load_q;
            REG_COUNT:  RD = count_q;
            REG_STATUS: RD[STATUS_EXP] = exp_q;
            default:    RD = '0;
        endcase
    end

    assign irq = exp_q && ie_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with F_DIV=3 (tick every 4 clocks).
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    countdown_timer_if bus ();

    countdown_timer #(.F_DIV(3)) dut (
        .clk (clk),
        .rst (rst),
        .A   (bus.A),
        .WD  (bus.WD),
        .WE  (bus.WE),
        .RD  (bus.RD),
        .irq (bus.irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Expected value queued when the read is issued, popped once RD settles.
    task automatic rd(input logic [1:0] a, input logic [31:0] want, input string tag);
        exp_t e;
        bus.A  = a;
        bus.WE = 1'b0;
        e.tag = tag;
        e.val = want;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check(e.tag, bus.RD, e.val);
    endtask

    task automatic chk_irq(input logic want, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = {31'd0, want};
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check(e.tag, {31'd0, bus.irq}, e.val);
    endtask

    // One write, committed at the next posedge; returns 1 time unit after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.A  = 2'd0;
        bus.WD = '0;
        bus.WE = 1'b0;
        rst    = 1'b1;
        step(2);
        rst = 1'b0;

        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, $sformatf("reset_rd_a%0d", a));
        chk_irq(1'b0, "reset_irq");

        // One-shot: LOAD=2, CTRL=EN|IE
        wr(REG_LOAD, 32'd2);
        wr(REG_CTRL, 32'h5);
        rd(REG_COUNT, 32'd2, "oneshot_cnt_k0");
        rd(REG_CTRL, 32'h5, "oneshot_ctrl_run");
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k % 4 == 0)
                rd(REG_COUNT, (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0, $sformatf("oneshot_cnt_k%0d", k));
            if (k >= 11) chk_irq(k >= 12, $sformatf("oneshot_irq_k%0d", k));
        end
        rd(REG_STATUS, 32'd1, "oneshot_exp");
        rd(REG_CTRL, 32'h4, "oneshot_ctrl_done");
        step(5);
        rd(REG_COUNT, 32'd0, "done_cnt_holds");

        // W1C with WD=0 has no effect; clear collides with a new expiry
        wr(REG_STATUS, 32'd0);
        rd(REG_STATUS, 32'd1, "w1c_zero_noeffect");
        wr(REG_LOAD, 32'd0);
        wr(REG_CTRL, 32'h5);
        step(3);
        wr(REG_STATUS, 32'd1);
        rd(REG_STATUS, 32'd1, "clr_vs_expire_set_wins");
        rd(REG_CTRL, 32'h4, "load0_expire_done");
        wr(REG_STATUS, 32'd1);
        rd(REG_STATUS, 32'd0, "w1c_clear");
        chk_irq(1'b0, "w1c_irq_low");

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        wr(REG_LOAD, 32'd1);
        wr(REG_CTRL, 32'h7);
        step(8);
        rd(REG_STATUS, 32'd1, "per_exp_1");
        rd(REG_COUNT, 32'd1, "per_reload");
        rd(REG_CTRL, 32'h7, "per_stays_run");
        wr(REG_STATUS, 32'd1);
        rd(REG_STATUS, 32'd0, "per_cleared");
        step(7);
        rd(REG_STATUS, 32'd1, "per_exp_2");
        chk_irq(1'b1, "per_irq");
        wr(REG_CTRL, 32'h0);
        wr(REG_STATUS, 32'd1);
`else
        wr(REG_LOAD, 32'd1);
        wr(REG_CTRL, 32'h3);
        rd(REG_CTRL, 32'h1, "per_ignored");
        step(8);
        rd(REG_CTRL, 32'h0, "no_per_done");
        wr(REG_STATUS, 32'd1);
`endif

        // Stop mid-run holds COUNT; LOAD/COUNT writes during RUN
        wr(REG_LOAD, 32'd5);
        wr(REG_CTRL, 32'h1);
        step(8);
        rd(REG_COUNT, 32'd3, "stop_two_ticks");
        wr(REG_CTRL, 32'h0);
        rd(REG_CTRL, 32'h0, "stop_idle");
        step(10);
        rd(REG_COUNT, 32'd3, "stop_holds");
        wr(REG_LOAD, 32'd9);
        rd(REG_COUNT, 32'd3, "load_idle_no_count");
        rd(REG_LOAD, 32'd9, "load_readback");
        wr(REG_CTRL, 32'h1);
        rd(REG_COUNT, 32'd9, "restart_count");
        wr(REG_LOAD, 32'd7);
        wr(REG_COUNT, 32'h55);
        rd(REG_COUNT, 32'd9, "count_ro_load_run");

        // Reset mid-run wins over a simultaneous CTRL write
        wr(REG_LOAD, 32'd4);
        wr(REG_CTRL, 32'h5);
        step(2);
        @(negedge clk);
        rst    = 1'b1;
        bus.A  = REG_CTRL;
        bus.WD = 32'h5;
        bus.WE = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.WE = 1'b0;
        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, $sformatf("rst_mid_a%0d", a));
        chk_irq(1'b0, "rst_mid_irq");
        step(24);
        rd(REG_STATUS, 32'd0, "rst_no_expiry");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
